// File: rtl/riscv_muldiv_pkg.sv
// Shared op codes, FSM encoding and decode helpers for the RV32M/RV64M multiply/divide unit.
package riscv_muldiv_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_MUL    = 3'b000;
    localparam logic [OP_W-1:0] OP_MULH   = 3'b001;
    localparam logic [OP_W-1:0] OP_MULHSU = 3'b010;
    localparam logic [OP_W-1:0] OP_MULHU  = 3'b011;
    localparam logic [OP_W-1:0] OP_DIV    = 3'b100;
    localparam logic [OP_W-1:0] OP_DIVU   = 3'b101;
    localparam logic [OP_W-1:0] OP_REM    = 3'b110;
    localparam logic [OP_W-1:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [OP_W-1:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_a(input logic [OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/riscv_muldiv_unit_if.sv
// Core-to-muldiv request/response bundle; the core is master, the unit is slave.
interface riscv_muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result fixup.
module muldiv_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg,
    output logic [WIDTH-1:0] out
);
    assign out = neg ? (~in + WIDTH'(1)) : in;
endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a combinational multiplier.
module riscv_muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic                clock,
    input logic                reset_,
    riscv_muldiv_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned DW    = 2 * XLEN;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            sign_a, sign_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf;

    assign sign_a   = is_signed_a(bus.op) & bus.a[XLEN-1];
    assign sign_b   = is_signed_b(bus.op) & bus.b[XLEN-1];
    assign div_zero = is_div(bus.op) && (bus.b == '0);
    assign div_ovf  = is_div(bus.op) && is_signed_a(bus.op) && (bus.a == MOST_NEG) && (bus.b == '1);

    muldiv_negate #(.WIDTH(XLEN)) u_neg_a (.in(bus.a), .neg(sign_a), .out(abs_a));
    muldiv_negate #(.WIDTH(XLEN)) u_neg_b (.in(bus.b), .neg(sign_b), .out(abs_b));

    // One multiplier step: add multiplicand into the high half when the low bit is set, then shift right.
    logic [XLEN:0]   mul_sum;
    logic [DW-1:0]   mul_next;
    assign mul_sum  = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // One restoring-divide step: high half is the partial remainder, low half shifts dividend out / quotient in.
    logic [XLEN:0]   div_shift, div_diff;
    logic            div_bit;
    logic [DW-1:0]   div_next;
    assign div_shift = acc_q[DW-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_bit   = ~div_diff[XLEN];
    assign div_next  = {(div_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_bit};

    // Sign fixup acts on the full product so the high half sees the borrow from the low half.
    logic [DW-1:0]   fix_in, fix_out;
    logic            fix_neg;
    logic [XLEN-1:0] fix_sel;
    assign fix_in  = !is_div(op_q) ? acc_q
                   : {XLEN'(0), (is_rem(op_q) ? acc_q[DW-1:XLEN] : acc_q[XLEN-1:0])};
    assign fix_neg = is_rem(op_q) ? neg_a_q : (neg_a_q ^ neg_b_q);

    muldiv_negate #(.WIDTH(DW)) u_neg_fix (.in(fix_in), .neg(fix_neg), .out(fix_out));

    assign fix_sel = ((op_q == OP_MUL) || is_div(op_q)) ? fix_out[XLEN-1:0] : fix_out[DW-1:XLEN];

`ifdef MULDIV_FAST_MUL_EN
    logic [DW-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{XLEN{sign_a}}, bus.a};
    assign fast_b    = {{XLEN{is_signed_b(bus.op) & bus.b[XLEN-1]}}, bus.b};
    assign fast_prod = fast_a * fast_b;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    neg_a_d = sign_a;
                    neg_b_d = sign_b;
                    cnt_d   = CNT_W'(XLEN - 1);
                    opnd_d  = is_div(bus.op) ? abs_b : abs_a;
                    acc_d   = {XLEN'(0), (is_div(bus.op) ? abs_a : abs_b)};
                    if (div_zero) begin
                        result_d = is_rem(bus.op) ? bus.a : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = is_rem(bus.op) ? '0 : bus.a;
                        state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!is_div(bus.op)) begin
                        result_d = (bus.op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[DW-1:XLEN];
                        state_d  = S_DONE;
`endif
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = is_div(op_q) ? div_next : mul_next;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                result_d = fix_sel;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
